// File: rtl/frame_top2_reporter_if.sv
// Sample-in / result-out handshake bundle for frame_top2_reporter.
// The in_flush member exists only when TOP2_EARLY_FLUSH_EN is defined.
interface frame_top2_reporter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;
`ifdef TOP2_EARLY_FLUSH_EN
  logic                  in_flush;
`endif

  // Source of samples and sink of results.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
`ifdef TOP2_EARLY_FLUSH_EN
    output in_flush,
`endif
    output out_ready
  );

  // The reporter block itself.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
`ifdef TOP2_EARLY_FLUSH_EN
    input  in_flush,
`endif
    input  out_ready
  );
endinterface

// File: rtl/frame_top2_reporter.sv
// Per-frame largest / second-largest distinct value tracker; emits max1 then max2.
// Optional early frame termination via in_flush when TOP2_EARLY_FLUSH_EN is defined.
module frame_top2_reporter #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_top2_reporter_if.slave bus
);
  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    SEND_MAX1 = 2'd1,
    SEND_MAX2 = 2'd2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_max1;
  logic [DATA_WIDTH-1:0] r_max2;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;

  state_t                w_state_nxt;
  logic [CW-1:0]         w_count_nxt;
  logic [CW-1:0]         w_count_inc;
  logic [DATA_WIDTH-1:0] w_max1_nxt;
  logic [DATA_WIDTH-1:0] w_max2_nxt;
  logic                  w_out_valid_nxt;
  logic [DATA_WIDTH-1:0] w_out_data_nxt;
  logic                  w_out_last_nxt;
  logic                  w_accept;
  logic                  w_end;

  assign bus.in_ready  = (r_state == COLLECT);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

  assign w_accept    = bus.in_valid && (r_state == COLLECT);
  assign w_count_inc = r_count + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_max1_nxt      = r_max1;
    w_max2_nxt      = r_max2;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    w_end           = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_accept) begin
          w_count_nxt = w_count_inc;
          if (r_count == '0) begin
            w_max1_nxt = bus.in_data;
            w_max2_nxt = '0;
          end else if (bus.in_data > r_max1) begin
            w_max2_nxt = r_max1;
            w_max1_nxt = bus.in_data;
          end else if ((bus.in_data < r_max1) && (bus.in_data > r_max2)) begin
            w_max2_nxt = bus.in_data;
          end
          if (w_count_inc == CW'(FRAME_LEN)) w_end = 1'b1;
        end
`ifdef TOP2_EARLY_FLUSH_EN
        // A flush is meaningful only if the frame holds at least one sample.
        if (bus.in_flush && (w_accept || (r_count != '0))) w_end = 1'b1;
`endif
        // The first result word carries the max1 that includes this edge's sample.
        if (w_end) begin
          w_state_nxt     = SEND_MAX1;
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = w_max1_nxt;
          w_out_last_nxt  = 1'b0;
        end
      end
      SEND_MAX1: begin
        if (bus.out_ready) begin
          w_state_nxt    = SEND_MAX2;
          w_out_data_nxt = r_max2;
          w_out_last_nxt = 1'b1;
        end
      end
      SEND_MAX2: begin
        if (bus.out_ready) begin
          w_state_nxt     = COLLECT;
          w_count_nxt     = '0;
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= COLLECT;
      r_count     <= '0;
      r_max1      <= '0;
      r_max2      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_max1      <= w_max1_nxt;
      r_max2      <= w_max2_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end
endmodule

// File: tb/tb_frame_top2_reporter.sv
// Self-checking bench for frame_top2_reporter (FRAME_LEN=4) with a result scoreboard.
// Exercises the in_flush path when TOP2_EARLY_FLUSH_EN is defined.
module tb_frame_top2_reporter;
  localparam int DW = 8;
  localparam int FL = 4;

  typedef struct packed {
    logic [3:0][DW-1:0] s;
    logic [DW-1:0]      e1;
    logic [DW-1:0]      e2;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  frame_top2_reporter_if #(.DATA_WIDTH(DW)) bus ();

  frame_top2_reporter #(
    .DATA_WIDTH(DW),
    .FRAME_LEN (FL)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [DW-1:0] a, b, c, d, e1, e2);
    vec_t v;
    v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
    v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic push_exp(input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    q.push_back({e1, 1'b0});
    q.push_back({e2, 1'b1});
  endtask

  // Scoreboard: every output handshake pops one expected word.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got data %0d last %0d, expected no output", bus.out_data, bus.out_last);
      end else begin
        e = q.pop_front();
        check("out_data", {24'd0, bus.out_data}, {24'd0, e.d});
        check("out_last", {31'd0, bus.out_last}, {31'd0, e.l});
      end
    end
  end

  task automatic send_sample(input logic [DW-1:0] x);
    int   budget;
    logic acc;
    budget = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 50);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: sample %0d not accepted, expected acceptance", x);
    end
  endtask

  task automatic send_frame(input vec_t v, input bit keep_valid);
    push_exp(v.e1, v.e2);
    for (int i = 0; i < FL; i++) send_sample(v.s[i]);
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (q.size() != 0 && b < 100) begin
      @(posedge clk);
      b++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);
    q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 0);
    check({tag, "_out_data"},  {24'd0, bus.out_data},  0);
    check({tag, "_out_last"},  {31'd0, bus.out_last},  0);
    check({tag, "_in_ready"},  {31'd0, bus.in_ready},  1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
`ifdef TOP2_EARLY_FLUSH_EN
    bus.in_flush  = 1'b0;
`endif
    tbl[0] = mk(8'd3,   8'd9,   8'd5,   8'd7,  8'd9,   8'd7);
    tbl[1] = mk(8'd6,   8'd6,   8'd6,   8'd6,  8'd6,   8'd0);
    tbl[2] = mk(8'd1,   8'd2,   8'd3,   8'd4,  8'd4,   8'd3);
    tbl[3] = mk(8'd10,  8'd8,   8'd2,   8'd1,  8'd10,  8'd8);
    tbl[4] = mk(8'd0,   8'd0,   8'd0,   8'd0,  8'd0,   8'd0);
    tbl[5] = mk(8'd255, 8'd254, 8'd255, 8'd1,  8'd255, 8'd254);
    tbl[6] = mk(8'd5,   8'd3,   8'd4,   8'd4,  8'd5,   8'd4);
    tbl[7] = mk(8'd2,   8'd7,   8'd7,   8'd2,  8'd7,   8'd2);

    #12;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic frame with latency check on the final sample.
    push_exp(8'd9, 8'd7);
    send_sample(8'd3);
    send_sample(8'd9);
    send_sample(8'd5);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd7;
    @(negedge clk);
    check("pre_last_out_valid", {31'd0, bus.out_valid}, 0);
    check("pre_last_in_ready",  {31'd0, bus.in_ready},  1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("latency_out_valid", {31'd0, bus.out_valid}, 1);
    check("latency_in_ready",  {31'd0, bus.in_ready},  0);
    wait_drain();

    // Table of frames with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i], 1'b0);
      wait_drain();
    end

    // Backpressure on the first result word.
    bus.out_ready = 1'b0;
    send_frame(tbl[0], 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, bus.out_valid}, 1);
      check("bp_out_data",  {24'd0, bus.out_data},  9);
      check("bp_out_last",  {31'd0, bus.out_last},  0);
      check("bp_in_ready",  {31'd0, bus.in_ready},  0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_last && bus.out_ready) seen = 1'b1;
    end
    check("bp_last_seen", {31'd0, seen}, 1);
    check("bp_in_ready_at_last", {31'd0, bus.in_ready}, 0);
    @(negedge clk);
    check("bp_in_ready_after_last", {31'd0, bus.in_ready}, 1);
    check("bp_out_valid_after_last", {31'd0, bus.out_valid}, 0);
    wait_drain();

    // Reset in the middle of a frame.
    send_sample(8'd200);
    send_sample(8'd100);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("rst_mid_frame");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset while a result word is waiting.
    bus.out_ready = 1'b0;
    send_sample(8'd200);
    send_sample(8'd100);
    send_sample(8'd50);
    send_sample(8'd25);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_tx_pre_valid", {31'd0, bus.out_valid}, 1);
    check("rst_tx_pre_data",  {24'd0, bus.out_data},  200);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("rst_mid_tx");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_frame(tbl[2], 1'b0);
    wait_drain();

    // Back-to-back frames, in_valid never dropped between them.
    send_frame(tbl[0], 1'b1);
    send_frame(mk(8'd250, 8'd250, 8'd1, 8'd0, 8'd250, 8'd1), 1'b0);
    wait_drain();

`ifdef TOP2_EARLY_FLUSH_EN
    // Flush after two samples.
    push_exp(8'd12, 8'd5);
    send_sample(8'd5);
    send_sample(8'd12);
    bus.in_valid = 1'b0;
    bus.in_flush = 1'b1;
    @(posedge clk); #1;
    bus.in_flush = 1'b0;
    check("flush_out_valid", {31'd0, bus.out_valid}, 1);
    wait_drain();

    // Flush on an empty frame is ignored.
    bus.in_flush = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.in_flush = 1'b0;
    check("flush_empty_out_valid", {31'd0, bus.out_valid}, 0);
    check("flush_empty_in_ready",  {31'd0, bus.in_ready},  1);

    // Flush coinciding with an accepted sample includes that sample.
    push_exp(8'd8, 8'd3);
    send_sample(8'd3);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd8;
    bus.in_flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_flush = 1'b0;
    wait_drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_top2_reporter.md
Name: frame_top2_reporter

Overview:
Frame-based producer side of the team's streaming second-largest tracker. Accepts a sample stream over a valid/ready handshake and tracks the largest and second-largest distinct values per frame of FRAME_LEN samples. At frame end it transmits two result words, max1 then max2, over an output valid/ready handshake. It sits between a sample source and any downstream consumer of per-frame statistics.

Parameters:
DATA_WIDTH, 8, width of samples and result words.
FRAME_LEN, 8, samples per frame; legal range is FRAME_LEN >= 2.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  sample valid.
in_data  input  DATA_WIDTH  sample value, unsigned.
in_ready  output  1  block can accept a sample; high only in COLLECT.
out_valid  output  1  result word valid.
out_data  output  DATA_WIDTH  result word: max1, then max2.
out_last  output  1  high with the max2 word.
out_ready  input  1  downstream accepts the result word.

Behaviour:
- Reset: asserting rst (low) immediately sets:
  - state = COLLECT, count = 0, max1 = 0, max2 = 0;
  - out_valid = 0, out_data = 0, out_last = 0;
  - in_ready = 1 (decoded from state).
  Reset mid-frame or mid-transmit discards the partial frame and any unsent results.
- All comparisons are unsigned. count width is $clog2(FRAME_LEN+1).
- A sample is accepted on a clock edge where in_valid && in_ready.
- COLLECT, update rule for accepted sample x:
  - First sample of frame (count == 0): max1 <= x, max2 <= 0.
  - Otherwise, if x > max1: max2 <= max1, max1 <= x.
  - Otherwise, if x < max1 && x > max2: max2 <= x.
  - Otherwise (x == max1, or x <= max2): no change. max2 is the second-largest distinct value; it is 0 if none exists.
  - count increments on each accept.
- Frame end: when the accepted sample makes count == FRAME_LEN:
  - that sample's update is applied on the same edge;
  - state -> SEND_MAX1 on the same edge;
  - in_ready is 0 from the next cycle onward.
- SEND_MAX1:
  - out_valid = 1, out_data = max1 (the post-update value), out_last = 0.
  - On out_valid && out_ready: state -> SEND_MAX2.
- SEND_MAX2:
  - out_valid = 1, out_data = max2, out_last = 1.
  - On handshake: state -> COLLECT, count <= 0, out_valid <= 0, out_last <= 0.
- Latency: out_valid rises 1 cycle after the final sample is accepted. The minimum frame-to-frame gap is 2 cycles with out_ready held high.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable and in_ready stays 0. Samples presented during SEND_* are not accepted; the source must hold them.
- out_ready asserted while out_valid = 0 is ignored.
- Output registers: out_valid, out_data and out_last are registered, with no combinational path from the in_* ports.
- No sample is accepted in the cycle the block returns to COLLECT. in_ready rises the cycle after the SEND_MAX2 handshake.

Optional Feature:
Macro TOP2_EARLY_FLUSH_EN.
- Defined:
  - Adds input port in_flush (1 bit), sampled only in COLLECT.
  - in_flush = 1 with count > 0: frame ends early and state -> SEND_MAX1 next edge.
  - If a sample is accepted on the same edge as in_flush, that sample's update is applied first, then the frame ends.
  - in_flush with count == 0 and no accepted sample is ignored.
  - in_flush outside COLLECT is ignored.
- Undefined: port in_flush is absent. Frames end only at count == FRAME_LEN.

Test Plan:
1. DATA_WIDTH=8, FRAME_LEN=4, samples 3,9,5,7, out_ready=1 -> out_data 9 (out_last 0), then 7 (out_last 1). out_valid rises 1 cycle after sample 7 is accepted.
2. Samples 6,6,6,6 -> 6 then 0. Samples 1,2,3,4 -> 4 then 3. Samples 10,8,2,1 -> 10 then 8.
3. Samples 3,9,5,7, out_ready held 0 for 3 cycles -> out_valid=1, out_data=9 stable, in_ready=0 throughout. Then out_ready=1 -> 9, 7 delivered, and in_ready=1 one cycle after the last handshake.
4. Reset asserted after samples 200,100 -> all outputs 0 immediately. Next frame 1,2,3,4 -> 4, 3 (no stale 200).
5. Back-to-back frames 3,9,5,7 then 250,250,1,0 with in_valid held high -> 9,7 then 250,1. No sample is lost or double-counted.
6. With TOP2_EARLY_FLUSH_EN defined: samples 5,12 then in_flush -> 12, 5. in_flush with count=0 produces no output.
